// File: rtl/rr_mux_select.sv
// rr_mux_select: round-robin arbiter driving a mux select plus a one-hot grant.
// Define RR_MUX_SELECT_TIMEOUT_EN to force release after TIMEOUT busy cycles (adds `expired`).
module rr_mux_select #(
  parameter int N = 4,
  parameter int TIMEOUT = 16,
  localparam int SW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  input  logic          done,
  output logic [SW-1:0] s,
  output logic [N-1:0]  grant,
  output logic          valid
`ifdef RR_MUX_SELECT_TIMEOUT_EN
  ,
  output logic          expired
`endif
);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t        state_q;
  logic [SW-1:0] s_q, ptr_q, rot_d;
  logic [N-1:0]  grant_q;
  logic [SW:0]   pick_idle_d, pick_rel_d;
  logic          rel_d, forced_d;
  // Result is {found, index}: first requester scanning from p upward, wrapping modulo N.
  function automatic logic [SW:0] pick(input logic [N-1:0] r, input logic [SW-1:0] p);
    logic [SW:0] res;
    res = '0;
    for (int k = N - 1; k >= 0; k--) begin
      int j;
      j = (int'(p) + k) % N;
      if (r[j]) res = {1'b1, SW'(j)};
    end
    return res;
  endfunction
`ifdef RR_MUX_SELECT_TIMEOUT_EN
  logic [7:0] cnt_q;
  logic       expired_q;
  assign forced_d = (cnt_q == 8'(TIMEOUT - 1)) && !(done || !req[s_q]);
  assign expired  = expired_q;
`else
  assign forced_d = 1'b0;
`endif
  always_comb begin
    rot_d       = (int'(s_q) == N - 1) ? '0 : s_q + 1'b1;
    rel_d       = done || !req[s_q] || forced_d;
    pick_idle_d = pick(req, ptr_q);
    pick_rel_d  = pick(req, rot_d);
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      s_q     <= '0;
      ptr_q   <= '0;
      grant_q <= '0;
`ifdef RR_MUX_SELECT_TIMEOUT_EN
      cnt_q     <= '0;
      expired_q <= 1'b0;
`endif
    end else begin
`ifdef RR_MUX_SELECT_TIMEOUT_EN
      expired_q <= 1'b0;
`endif
      if (state_q == IDLE) begin
        if (pick_idle_d[SW]) begin
          state_q <= BUSY;
          s_q     <= pick_idle_d[SW-1:0];
          grant_q <= N'(1) << pick_idle_d[SW-1:0];
`ifdef RR_MUX_SELECT_TIMEOUT_EN
          cnt_q <= '0;
`endif
        end
      end else if (rel_d) begin
        ptr_q <= rot_d;
`ifdef RR_MUX_SELECT_TIMEOUT_EN
        cnt_q     <= '0;
        expired_q <= forced_d;
`endif
        if (pick_rel_d[SW]) begin
          s_q     <= pick_rel_d[SW-1:0];
          grant_q <= N'(1) << pick_rel_d[SW-1:0];
        end else begin
          state_q <= IDLE;
          grant_q <= '0;
        end
      end
`ifdef RR_MUX_SELECT_TIMEOUT_EN
      else cnt_q <= cnt_q + 8'd1;
`endif
    end
  end
  assign s     = s_q;
  assign grant = grant_q;
  assign valid = (state_q == BUSY);
endmodule

// File: tb/tb_rr_mux_select.sv
// tb_rr_mux_select: directed checks of round-robin grant, release, wrap and reset behaviour.
module tb_rr_mux_select;
  logic       clk = 0, rst = 0, done = 0;
  logic [3:0] req = '0;
  logic [1:0] s;
  logic [3:0] grant;
  logic       valid;
  int total = 0, bad = 0;
`ifdef RR_MUX_SELECT_TIMEOUT_EN
  logic expired;
`endif
  rr_mux_select #(.N(4), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .req(req), .done(done),
    .s(s), .grant(grant), .valid(valid)
`ifdef RR_MUX_SELECT_TIMEOUT_EN
    , .expired(expired)
`endif
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    total++;
    if ((grant & (grant - 4'd1)) !== 4'd0 || valid !== (|grant) || (valid && grant[s] !== 1'b1)) begin
      bad++;
      $display("FAIL invariant: got s=%0d grant=%b valid=%b", s, grant, valid);
    end
  end
  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic expect_out(input string name, input logic [1:0] es, input logic [3:0] eg, input logic ev);
    total++;
    if ({s, grant, valid} !== {es, eg, ev}) begin
      bad++;
      $display("FAIL %s: got s=%0d grant=%b valid=%b, want s=%0d grant=%b valid=%b", name, s, grant, valid, es, eg, ev);
    end
  endtask
  task automatic do_reset;
    rst = 0; req = '0; done = 0;
    tick();
    rst = 1;
  endtask
  task automatic test_reset;
    rst = 0; req = 4'b1111;
    tick(2);
    expect_out("reset_hold", 2'd0, 4'b0000, 1'b0);
    rst = 1;
    tick();
    expect_out("reset_release", 2'd0, 4'b0001, 1'b1);
  endtask
  task automatic test_rotation;
    logic [1:0] seq [4] = '{2'd1, 2'd2, 2'd3, 2'd0};
    for (int i = 0; i < 4; i++) begin
      tick(2);
      expect_out("rot_hold", seq[(i + 3) % 4], 4'b0001 << seq[(i + 3) % 4], 1'b1);
      done = 1;
      tick();
      done = 0;
      expect_out("rot_next", seq[i], 4'b0001 << seq[i], 1'b1);
    end
  endtask
  task automatic test_sparse_wrap;
    do_reset();
    req = 4'b0100;
    tick();
    expect_out("sparse_first", 2'd2, 4'b0100, 1'b1);
    req = 4'b0101; done = 1;
    tick();
    expect_out("sparse_wrap", 2'd0, 4'b0001, 1'b1);
    tick();
    expect_out("sparse_next", 2'd2, 4'b0100, 1'b1);
    req = 4'b0000;
    tick();
    expect_out("sparse_idle", 2'd2, 4'b0000, 1'b0);
    tick();
    done = 0;
    expect_out("done_idle_ignored", 2'd2, 4'b0000, 1'b0);
  endtask
  task automatic test_drop_sole;
    do_reset();
    req = 4'b0010;
    tick();
    expect_out("sole_grant", 2'd1, 4'b0010, 1'b1);
    req = 4'b1111;
    tick(3);
    expect_out("hold_no_release", 2'd1, 4'b0010, 1'b1);
    req = 4'b0000;
    tick();
    expect_out("req_drop", 2'd1, 4'b0000, 1'b0);
    req = 4'b0010;
    tick();
    expect_out("regrant", 2'd1, 4'b0010, 1'b1);
    done = 1;
    tick();
    done = 0;
    expect_out("sole_done", 2'd1, 4'b0010, 1'b1);
  endtask
  task automatic test_back_to_back;
    do_reset();
    req = 4'b1001;
    tick();
    expect_out("b2b_first", 2'd0, 4'b0001, 1'b1);
    req = 4'b1000;
    tick();
    expect_out("b2b_drop_handover", 2'd3, 4'b1000, 1'b1);
    req = 4'b1010; done = 1;
    tick();
    done = 0;
    expect_out("b2b_wrap_handover", 2'd1, 4'b0010, 1'b1);
  endtask
  task automatic test_mid_reset;
    do_reset();
    req = 4'b0100;
    tick();
    expect_out("mid_busy", 2'd2, 4'b0100, 1'b1);
    rst = 0;
    tick();
    expect_out("mid_reset", 2'd0, 4'b0000, 1'b0);
    rst = 1; req = 4'b1100;
    tick();
    expect_out("mid_after", 2'd2, 4'b0100, 1'b1);
  endtask
  task automatic test_timeout;
    do_reset();
    req = 4'b0011;
    tick();
    expect_out("to_first", 2'd0, 4'b0001, 1'b1);
`ifdef RR_MUX_SELECT_TIMEOUT_EN
    for (int r = 0; r < 2; r++) begin
      tick(3);
      total++;
      if (expired !== 1'b0 || s !== 2'(r)) begin
        bad++;
        $display("FAIL to_hold: got s=%0d expired=%b, want s=%0d expired=0", s, expired, r);
      end
      tick();
      total++;
      if (expired !== 1'b1 || s !== 2'(1 - r)) begin
        bad++;
        $display("FAIL to_expire: got s=%0d expired=%b, want s=%0d expired=1", s, expired, 1 - r);
      end
    end
    tick();
    total++;
    if (expired !== 1'b0) begin
      bad++;
      $display("FAIL to_pulse_end: got expired=%b, want 0", expired);
    end
`else
    tick(20);
    expect_out("no_timeout", 2'd0, 4'b0001, 1'b1);
`endif
  endtask
  initial begin
    test_reset();
    test_rotation();
    test_sparse_wrap();
    test_drop_sole();
    test_back_to_back();
    test_mid_reset();
    test_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
